uart_ctrl_fifo: RTL and testbench

Parametrised UART bus controller that sits between the simple bus slave port and the UART RX/TX serialisers. It buffers received bytes and bytes queued for transmit in independent FIFOs of configurable depth, and launches transmits autonomously through a TX-launch state machine. It raises threshold- and error-driven interrupts and exposes status, control and FIFO-level registers, so software no longer needs to service every byte.

---
 rtl/uart_ctrl_fifo.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_uart_ctrl_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ctrl_fifo.sv
// UART bus controller: register file, RX/TX byte FIFOs, autonomous TX launch
// and threshold/error interrupts between a simple bus slave port and the serialisers.
module uart_ctrl_fifo #(
    parameter int DATA_W   = 32,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy_,
    output logic              irq_rx,
    output logic              irq_tx,
    input  logic              rx_busy,
    input  logic              rx_end,
    input  logic [7:0]        rx_data,
    input  logic              tx_busy,
    input  logic              tx_end,
    output logic              tx_start,
    output logic [7:0]        tx_data
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam int TX_CW = TX_AW + 1;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_LEVEL  = 2'd3;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_WAIT_BUSY,
        TX_WAIT_END
    } tx_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]        rx_mem [RX_DEPTH];
    logic [7:0]        tx_mem [TX_DEPTH];

    logic [RX_AW-1:0]  rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [RX_CW-1:0]  rx_cnt_q, rx_cnt_d;
    logic [TX_AW-1:0]  tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [TX_CW-1:0]  tx_cnt_q, tx_cnt_d;

    logic              rx_ovf_q, rx_ovf_d;
    logic              tx_ovf_q, tx_ovf_d;
    logic              rx_ie_q, rx_ie_d;
    logic              tx_ie_q, tx_ie_d;
    logic [7:0]        rx_thresh_q, rx_thresh_d;

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rdy_q, rdy_d;
    logic              irq_rx_q, irq_rx_d;
    logic              irq_tx_q, irq_tx_d;

    tx_state_e         tx_state_q, tx_state_d;
    logic              end_seen_q, end_seen_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic acc, rd_acc, wr_acc;
    logic rx_pop, rx_push, rx_drop, rx_flush, rx_full, rx_nempty;
    logic tx_pop, tx_push, tx_drop, tx_flush, tx_full, tx_wr, tx_idle;
    logic w1c_rx, w1c_tx, ctrl_wr;
    logic [7:0] thresh_eff;
    logic [DATA_W-1:0] rd_mux;
    logic unused_wr_bits;

    assign acc      = !cs_ && !as_;
    assign rd_acc   = acc && rw;
    assign wr_acc   = acc && !rw;

    assign ctrl_wr  = wr_acc && (addr == REG_CTRL);
    assign rx_flush = ctrl_wr && wr_data[2];
    assign tx_flush = ctrl_wr && wr_data[3];
    assign w1c_rx   = wr_acc && (addr == REG_STATUS) && wr_data[2];
    assign w1c_tx   = wr_acc && (addr == REG_STATUS) && wr_data[3];

    assign rx_full   = (rx_cnt_q == RX_CW'(RX_DEPTH));
    assign rx_nempty = (rx_cnt_q != '0);
    assign tx_full   = (tx_cnt_q == TX_CW'(TX_DEPTH));
    assign tx_idle   = (tx_cnt_q == '0) && (tx_state_q == TX_IDLE);

    // A pop frees the slot in the same edge, so a full FIFO still accepts the byte.
    assign rx_pop  = rd_acc && (addr == REG_DATA) && rx_nempty;
    assign rx_push = rx_end && !rx_flush && (!rx_full || rx_pop);
    assign rx_drop = rx_end && !rx_flush && rx_full && !rx_pop;

    assign tx_wr   = wr_acc && (addr == REG_DATA);
    assign tx_push = tx_wr && !tx_full;
    assign tx_drop = tx_wr && tx_full;
    assign tx_pop  = (tx_state_q == TX_START);

    assign thresh_eff = (rx_thresh_q == 8'd0) ? 8'd1 : rx_thresh_q;

    assign unused_wr_bits = &{1'b0, wr_data[DATA_W-1:16]};

    // ------------------------------------------------------------------
    // Read mux (state before this cycle's edge)
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        case (addr)
            REG_STATUS: begin
                rd_mux[0] = rx_nempty;
                rd_mux[1] = !tx_full;
                rd_mux[2] = rx_ovf_q;
                rd_mux[3] = tx_ovf_q;
                rd_mux[4] = rx_busy;
                rd_mux[5] = tx_busy;
                rd_mux[6] = tx_idle;
            end
            REG_DATA: begin
                if (rx_nempty) rd_mux[7:0] = rx_mem[rx_rp_q];
            end
            REG_CTRL: begin
                rd_mux[0]    = rx_ie_q;
                rd_mux[1]    = tx_ie_q;
                rd_mux[15:8] = rx_thresh_q;
            end
            default: begin
                rd_mux[RX_CW-1:0]   = rx_cnt_q;
                rd_mux[16 +: TX_CW] = tx_cnt_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state: bus, FIFOs, flags
    // ------------------------------------------------------------------
    always_comb begin
        rd_data_d   = rd_acc ? rd_mux : rd_data_q;
        rdy_d       = !acc;

        rx_ie_d     = rx_ie_q;
        tx_ie_d     = tx_ie_q;
        rx_thresh_d = rx_thresh_q;
        if (ctrl_wr) begin
            rx_ie_d     = wr_data[0];
            tx_ie_d     = wr_data[1];
            rx_thresh_d = wr_data[15:8];
        end

        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_flush) begin
            rx_wp_d  = '0;
            rx_rp_d  = '0;
            rx_cnt_d = '0;
        end else begin
            if (rx_push) rx_wp_d = rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_d = rx_rp_q + 1'b1;
            rx_cnt_d = rx_cnt_q + RX_CW'(rx_push) - RX_CW'(rx_pop);
        end

        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_flush) begin
            tx_wp_d  = '0;
            tx_rp_d  = '0;
            tx_cnt_d = '0;
        end else begin
            if (tx_push) tx_wp_d = tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_d = tx_rp_q + 1'b1;
            tx_cnt_d = tx_cnt_q + TX_CW'(tx_push) - TX_CW'(tx_pop);
        end

        // A fresh overflow in the same cycle as a clear is kept.
        rx_ovf_d = rx_ovf_q;
        if (w1c_rx || rx_flush) rx_ovf_d = 1'b0;
        if (rx_drop)            rx_ovf_d = 1'b1;

        tx_ovf_d = tx_ovf_q;
        if (w1c_tx || tx_flush) tx_ovf_d = 1'b0;
        if (tx_drop)            tx_ovf_d = 1'b1;

        irq_rx_d = rx_ie_q && ((9'(rx_cnt_q) >= 9'(thresh_eff)) || rx_ovf_q);
        irq_tx_d = tx_ie_q && (tx_idle || tx_ovf_q);
    end

    // ------------------------------------------------------------------
    // TX-launch FSM
    // ------------------------------------------------------------------
    always_comb begin
        tx_state_d = tx_state_q;
        end_seen_d = end_seen_q;
        case (tx_state_q)
            TX_IDLE: begin
                // A flush in this cycle empties the FIFO, so do not launch.
                if ((tx_cnt_q != '0) && !tx_busy && !tx_flush) tx_state_d = TX_START;
            end
            TX_START: begin
                tx_state_d = TX_WAIT_BUSY;
                end_seen_d = 1'b0;
            end
            TX_WAIT_BUSY: begin
                // An early tx_end is remembered so WAIT_END does not wait for another.
                if (tx_busy || tx_end) begin
                    tx_state_d = TX_WAIT_END;
                    end_seen_d = tx_end;
                end
            end
            default: begin
                if (tx_end || end_seen_q) begin
                    tx_state_d = TX_IDLE;
                    end_seen_d = 1'b0;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp_q     <= '0;
            rx_rp_q     <= '0;
            rx_cnt_q    <= '0;
            tx_wp_q     <= '0;
            tx_rp_q     <= '0;
            tx_cnt_q    <= '0;
            rx_ovf_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            rx_ie_q     <= 1'b0;
            tx_ie_q     <= 1'b0;
            rx_thresh_q <= '0;
            rd_data_q   <= '0;
            rdy_q       <= 1'b1;
            irq_rx_q    <= 1'b0;
            irq_tx_q    <= 1'b0;
            tx_state_q  <= TX_IDLE;
            end_seen_q  <= 1'b0;
        end else begin
            rx_wp_q     <= rx_wp_d;
            rx_rp_q     <= rx_rp_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_wp_q     <= tx_wp_d;
            tx_rp_q     <= tx_rp_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_ie_q     <= rx_ie_d;
            tx_ie_q     <= tx_ie_d;
            rx_thresh_q <= rx_thresh_d;
            rd_data_q   <= rd_data_d;
            rdy_q       <= rdy_d;
            irq_rx_q    <= irq_rx_d;
            irq_tx_q    <= irq_tx_d;
            tx_state_q  <= tx_state_d;
            end_seen_q  <= end_seen_d;
        end
    end

    // Storage arrays need no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp_q] <= rx_data;
        if (tx_push) tx_mem[tx_wp_q] <= wr_data[7:0];
    end

    assign rd_data  = rd_data_q;
    assign rdy_     = rdy_q;
    assign irq_rx   = irq_rx_q;
    assign irq_tx   = irq_tx_q;
    assign tx_start = (tx_state_q == TX_START);
    assign tx_data  = tx_start ? tx_mem[tx_rp_q] : 8'h00;

endmodule

// File: tb/tb_uart_ctrl_fifo.sv
// Bench for uart_ctrl_fifo: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model and a modelled serialiser.
module tb_uart_ctrl_fifo;
    localparam int DW  = 32;
    localparam int RXD = 4;
    localparam int TXD = 4;

    logic clk = 1'b0;
    logic rst, cs_, as_, rw;
    logic [1:0] addr;
    logic [DW-1:0] wr_data, rd_data;
    logic rdy_, irq_rx, irq_tx, rx_busy, rx_end, tx_busy, tx_end, tx_start;
    logic [7:0] rx_data, tx_data;

    always #5 clk = ~clk;

    uart_ctrl_fifo #(.DATA_W(DW), .RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
        .clk(clk), .rst(rst), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_),
        .irq_rx(irq_rx), .irq_tx(irq_tx),
        .rx_busy(rx_busy), .rx_end(rx_end), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_end(tx_end), .tx_start(tx_start), .tx_data(tx_data)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain queues, flags and a launch phase
    // (0 idle, 1 start, 2 wait busy, 3 wait end).
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    bit          m_rxo, m_txo, m_rie, m_tie, m_pend;
    int          m_thr, m_ph;
    logic [31:0] e_rd;
    int          ser;
    bit          fast;
    int          ts_cnt;
    logic [7:0]  ts_q[$];

    task automatic bus_idle();
        cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = 2'd0; wr_data = '0; rx_end = 1'b0;
    endtask

    // One clock: predict from the pre-edge model, clock, compare, then drive next inputs.
    task automatic step();
        logic [31:0] rv;
        bit acc, rd, wr, pop, rfl, tfl, tidle;
        int rxn, txn, thr;
        logic e_rdy, e_irx, e_itx, e_txs;
        logic [7:0] e_txd;
        rv = '0;
        if (rst) begin
            rxq.delete(); txq.delete();
            m_rxo = 0; m_txo = 0; m_rie = 0; m_tie = 0; m_thr = 0; m_ph = 0; m_pend = 0;
            e_rd = '0; e_rdy = 1'b1; e_irx = 1'b0; e_itx = 1'b0; ser = 0;
        end else begin
            acc = !cs_ && !as_; rd = acc && rw; wr = acc && !rw;
            rxn = rxq.size(); txn = txq.size();
            tidle = (txn == 0) && (m_ph == 0);
            thr = (m_thr == 0) ? 1 : m_thr;
            e_irx = m_rie && ((rxn >= thr) || m_rxo);
            e_itx = m_tie && (tidle || m_txo);
            e_rdy = !acc;
            case (addr)
                2'd0: rv = {25'd0, tidle, tx_busy, rx_busy, m_txo, m_rxo, (txn < TXD), (rxn > 0)};
                2'd1: rv = (rxn > 0) ? {24'd0, rxq[0]} : 32'd0;
                2'd2: rv = (32'(m_thr) << 8) | (32'(m_tie) << 1) | 32'(m_rie);
                default: rv = (32'(txn) << 16) | 32'(rxn);
            endcase
            if (rd) e_rd = rv;
            pop = rd && addr == 2'd1 && rxn > 0;
            rfl = wr && addr == 2'd2 && wr_data[2];
            tfl = wr && addr == 2'd2 && wr_data[3];
            if (wr && addr == 2'd0 && wr_data[2]) m_rxo = 0;
            if (wr && addr == 2'd0 && wr_data[3]) m_txo = 0;
            if (rfl) begin
                rxq.delete(); m_rxo = 0;
            end else begin
                if (pop) void'(rxq.pop_front());
                if (rx_end) begin
                    if (rxn < RXD || pop) rxq.push_back(rx_data);
                    else m_rxo = 1;
                end
            end
            case (m_ph)
                0: if (txn > 0 && !tx_busy && !tfl) m_ph = 1;
                1: begin m_ph = 2; m_pend = 0; void'(txq.pop_front()); end
                2: if (tx_busy || tx_end) begin m_ph = 3; m_pend = tx_end; end
                default: if (tx_end || m_pend) begin m_ph = 0; m_pend = 0; end
            endcase
            if (wr && addr == 2'd1) begin
                if (txn == TXD) m_txo = 1;
                else txq.push_back(wr_data[7:0]);
            end
            if (tfl) begin txq.delete(); m_txo = 0; end
            if (wr && addr == 2'd2) begin
                m_rie = wr_data[0]; m_tie = wr_data[1]; m_thr = int'(wr_data[15:8]);
            end
        end
        e_txs = (m_ph == 1);
        e_txd = e_txs ? txq[0] : 8'h00;
        @(posedge clk); #1;
        chk("rdy_", rdy_, e_rdy);
        chk("rd_data", rd_data, e_rd);
        chk("irq_rx", irq_rx, e_irx);
        chk("irq_tx", irq_tx, e_itx);
        chk("tx_start", tx_start, e_txs);
        chk("tx_data", tx_data, e_txd);
        if (tx_start === 1'b1) begin ts_cnt++; ts_q.push_back(tx_data); end
        // Serialiser: busy for 10 cycles then a tx_end pulse, or an immediate tx_end when fast.
        if (ser > 1)       begin tx_busy = 1'b1; tx_end = 1'b0; end
        else if (ser == 1) begin tx_busy = 1'b0; tx_end = 1'b1; end
        else               begin tx_busy = 1'b0; tx_end = 1'b0; end
        if (ser > 0) ser--;
        if (e_txs) ser = fast ? 1 : 11;
        bus_idle();
    endtask

    task automatic bus(input bit r, input logic [1:0] a, input logic [31:0] d);
        cs_ = 1'b0; as_ = 1'b0; rw = r; addr = a; wr_data = d;
        step();
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_end = 1'b1; rx_data = b;
        step();
    endtask

    initial begin
        int w;
        bus_idle();
        rst = 1'b1; rx_busy = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; tx_end = 1'b0;
        ser = 0; fast = 0; ts_cnt = 0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state read-back
        bus(1, 2'd0, 0);
        chk("rst_status", rd_data, 32'h42);
        chk("rdy_pulse", rdy_, 1'b0);
        step();
        chk("rdy_release", rdy_, 1'b1);

        // Three queued bytes launched in order
        bus(0, 2'd2, 32'h2);
        ts_q.delete(); ts_cnt = 0;
        bus(0, 2'd1, 32'h41); bus(0, 2'd1, 32'h42); bus(0, 2'd1, 32'h43);
        repeat (80) step();
        chk("tx_count_pulses", ts_cnt, 3);
        for (int i = 0; i < 3; i++)
            chk("tx_byte_order", (i < ts_q.size()) ? 32'(ts_q[i]) : 32'hFFFF_FFFF, 32'h41 + i);
        bus(1, 2'd0, 0);
        chk("tx_idle_bit", rd_data[6], 1'b1);
        chk("irq_tx_idle", irq_tx, 1'b1);

        // RX overflow and drain
        for (int i = 0; i < 5; i++) rx_byte(8'h10 + 8'(i));
        bus(1, 2'd3, 0);
        chk("rx_level_full", rd_data[15:0], 16'd4);
        bus(1, 2'd0, 0);
        chk("rx_ovf_set", rd_data[2], 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus(1, 2'd1, 0);
            chk("rx_pop_data", rd_data, 32'h10 + i);
        end
        bus(1, 2'd1, 0);
        chk("rx_empty_read", rd_data, 32'h0);
        bus(0, 2'd0, 32'h4);
        bus(1, 2'd0, 0);
        chk("rx_ovf_w1c", rd_data[2], 1'b0);

        // RX threshold interrupt
        bus(0, 2'd2, 32'h0301);
        rx_byte(8'hA0); rx_byte(8'hA1);
        step(); step();
        chk("irq_rx_below", irq_rx, 1'b0);
        rx_byte(8'hA2);
        chk("irq_rx_lag", irq_rx, 1'b0);
        step();
        chk("irq_rx_at_thr", irq_rx, 1'b1);
        bus(1, 2'd1, 0);
        step();
        chk("irq_rx_drop", irq_rx, 1'b0);

        // Full FIFO: pop and push in one cycle
        bus(0, 2'd2, 32'h0305);
        for (int i = 0; i < 4; i++) rx_byte(8'h20 + 8'(i));
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 2'd1; rx_end = 1'b1; rx_data = 8'h24;
        step();
        chk("full_pop_oldest", rd_data, 32'h20);
        bus(1, 2'd3, 0);
        chk("full_level_kept", rd_data[15:0], 16'd4);
        bus(1, 2'd0, 0);
        chk("full_no_ovf", rd_data[2], 1'b0);
        for (int i = 1; i < 5; i++) begin
            bus(1, 2'd1, 0);
            chk("full_drain", rd_data, 32'h20 + i);
        end

        // TX flush during an in-flight byte
        bus(0, 2'd2, 32'h0);
        ts_cnt = 0;
        for (int i = 0; i < 5; i++) bus(0, 2'd1, 32'h50 + i);
        w = 0;
        while (m_ph != 3 && w < 50) begin step(); w++; end
        chk("wait_end_timeout", (w < 50), 1'b1);
        bus(0, 2'd2, 32'h8);
        bus(1, 2'd3, 0);
        chk("tx_flush_level", rd_data[31:16], 16'd0);
        repeat (40) step();
        chk("tx_flush_starts", ts_cnt, 1);
        bus(1, 2'd0, 0);
        chk("tx_flush_idle", rd_data[6], 1'b1);

        // Random traffic, with one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            rst = (i == 1500);
            rx_busy = 1'($urandom_range(0, 1));
            fast = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin rx_end = 1'b1; rx_data = 8'($urandom); end
            if ($urandom_range(0, 2) == 0) begin
                cs_ = 1'b0; as_ = 1'b0; rw = 1'($urandom_range(0, 1));
                addr = 2'($urandom_range(0, 3)); wr_data = $urandom;
                if (!rw && addr == 2'd2 && $urandom_range(0, 7) != 0) wr_data[3:2] = 2'b00;
            end else if ($urandom_range(0, 9) == 0) begin
                cs_ = 1'b0;
            end
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
